mul_share_arbiter: RTL
======================

// Module: mul_share_arbiter
// PURPOSE
//  Shares one registered signed 8x8 array multiplier among N_REQ requesters.
//  - Arbitration is round-robin.
//  - The block sequences the multiplier's enable and returns each product tagged with the requester ID.
//  - Sits between requester logic and the multiplier; drives the multiplier's A/B/en and receives its 15-bit P.
// PARAMETERS
//  N_REQ   4   number of requesters (2..8)
//  ID_W    2   requester ID width, = clog2(N_REQ)
// PORTS
//  clk        in   1          clock; all state on rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  req_valid  in   N_REQ      per-requester operand valid
//  req_a      in   8*N_REQ    signed multiplicand, requester i in [8i+7:8i]
//  req_b      in   8*N_REQ    signed multiplier, requester i in [8i+7:8i]
//  req_ready  out  N_REQ      one-hot accept pulse; combinational
//  mul_a      out  8          operand A to multiplier (registered)
//  mul_b      out  8          operand B to multiplier (registered)
//  mul_en     out  1          multiplier capture enable (registered)
//  mul_p      in   15         multiplier registered product P
//  rsp_valid  out  1          result valid
//  rsp_id     out  ID_W       requester index owning the result
//  rsp_p      out  15         signed product
//  rsp_ready  in   1          result consumer ready
//  busy       out  1          high in any state other than IDLE
// BEHAVIOUR
//  Reset: every output register is 0 (mul_a, mul_b, mul_en, rsp_valid, rsp_id, rsp_p); state=IDLE; rr_ptr=N_REQ-1.
//  - Requester 0 therefore has first priority after reset.
//  - Reset asserted mid-operation aborts immediately; the in-flight product is discarded.
//  FSM (4 states):
//  - IDLE: if |req_valid, grant the first valid index searching rr_ptr+1, rr_ptr+2, ... (mod N_REQ).
//    - req_ready[g]=1 this cycle only.
//    - Latch req_a[g]->mul_a, req_b[g]->mul_b, g->rsp_id, rr_ptr<=g.
//    - Next state ISSUE.
//    - No valid: stay in IDLE; req_ready=0.
//  - ISSUE: mul_en=1 for exactly this cycle; the multiplier captures at the end of this cycle. Next state WAIT.
//  - WAIT: mul_en=0; mul_p now holds the product. rsp_p<=mul_p, rsp_valid<=1. Next state RESP.
//  - RESP: hold rsp_valid, rsp_id, rsp_p stable until rsp_ready=1.
//    - On the handshake cycle: rsp_valid<=0, next state IDLE.
//  Timing:
//  - Accept in cycle t -> mul_en high in t+1 -> rsp_valid high from t+3.
//  - Minimum 4 cycles per operation (IDLE, ISSUE, WAIT, RESP with rsp_ready=1).
//  - req_ready is never asserted outside IDLE; at most one bit is high per cycle.
//  Requester rules:
//  - Requesters hold req_valid and operands until req_ready; the arbiter does not check this.
//  - A requester dropping req_valid before grant is simply skipped.
//  - req_valid changes in states other than IDLE have no effect.
//  Width rule:
//  - The product is 15-bit two's complement, the multiplier output passed through unchanged.
//  - -128 * -128 wraps to 15'h4000 (-16384); this wrap is the documented behaviour, not an error.
//  mul_a and mul_b keep the last granted operands while idle, so the multiplier inputs do not toggle.
// TESTING
//  1. Reset with all inputs 0 -> all outputs 0, busy=0; release reset, no req -> state stays IDLE.
//  2. req_valid=4'b0001, a0=7, b0=-3 at cycle t:
//     - req_ready=0001 at t; mul_en=1 at t+1.
//     - rsp_valid=1 at t+3 with rsp_p=-21 (15'h7FEB), rsp_id=0.
//  3. req_valid=4'b1111 held, rsp_ready=1:
//     - Grant order 0,1,2,3,0.
//     - Each product returned with the matching rsp_id, one per 4 cycles.
//  4. rsp_ready=0 for 10 cycles in RESP:
//     - rsp_valid, rsp_id and rsp_p stay stable; req_ready stays 0; busy=1.
//     - Raise rsp_ready -> IDLE the next cycle.
//  5. a=-128, b=-128 -> rsp_p=15'h4000.
//     a=127, b=127 -> rsp_p=16129.
//     a=-1, b=1 -> rsp_p=15'h7FFF.
//  6. Assert rst_n=0 one cycle after mul_en:
//     - Outputs go to 0 asynchronously; no rsp_valid follows.
//     - rr_ptr restarts, so requester 0 is granted first.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin arbiter sharing one registered signed 8x8 multiplier
// Grants one requester at a time, sequences the multiplier enable and returns the tagged product.
module mul_share_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_REQ-1:0]   req_valid,
   input  logic [8*N_REQ-1:0] req_a,
   input  logic [8*N_REQ-1:0] req_b,
   output logic [N_REQ-1:0]   req_ready,
   output logic [7:0]         mul_a,
   output logic [7:0]         mul_b,
   output logic               mul_en,
   input  logic [14:0]        mul_p,
   output logic               rsp_valid,
   output logic [ID_W-1:0]    rsp_id,
   output logic [14:0]        rsp_p,
   input  logic               rsp_ready,
   output logic               busy
);
   localparam int CW = ID_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t          state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [7:0]      mul_a_q, mul_a_d;
   logic [7:0]      mul_b_q, mul_b_d;
   logic            mul_en_q, mul_en_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic [14:0]     rsp_p_q, rsp_p_d;

   logic            grant_found;
   logic [ID_W-1:0] grant_idx;
   logic [CW-1:0]   cand;

   // Rotating search that starts just after the previous winner
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand        = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         cand = {1'b0, rr_ptr_q} + CW'(k);
         if (cand >= CW'(N_REQ)) begin
            cand = cand - CW'(N_REQ);
         end
         if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = cand[ID_W-1:0];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         rr_ptr_q <= ID_W'(N_REQ - 1);
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (grant_found) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Operand registers are only rewritten on a grant so the multiplier inputs stay quiet when idle
   always_comb begin
      req_ready   = '0;
      rr_ptr_d    = rr_ptr_q;
      mul_a_d     = mul_a_q;
      mul_b_d     = mul_b_q;
      mul_en_d    = 1'b0;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_p_d     = rsp_p_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found) begin
               req_ready[grant_idx] = 1'b1;
               rr_ptr_d = grant_idx;
               mul_a_d  = req_a[{grant_idx, 3'b000} +: 8];
               mul_b_d  = req_b[{grant_idx, 3'b000} +: 8];
               rsp_id_d = grant_idx;
               mul_en_d = 1'b1;
            end
         end
         S_WAIT: begin
            rsp_p_d     = mul_p;
            rsp_valid_d = 1'b1;
         end
         S_RESP: begin
            if (rsp_ready) rsp_valid_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_a_q     <= '0;
         mul_b_q     <= '0;
         mul_en_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_p_q     <= '0;
      end else begin
         mul_a_q     <= mul_a_d;
         mul_b_q     <= mul_b_d;
         mul_en_q    <= mul_en_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_p_q     <= rsp_p_d;
      end
   end

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign mul_en    = mul_en_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_p     = rsp_p_q;
   assign busy      = (state_q != S_IDLE);

endmodule
